benes_sched: RTL and testbench

BENES_SCHED -- requirements
Module: benes_sched

---
 rtl/benes_pkg.sv | 22 ++
 rtl/benes_sched_wait_counter.sv | 23 ++
 rtl/benes_sched.sv | 199 +++++++++++++++++++
 tb/tb_benes_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/benes_pkg.sv
// Shared definitions for the Benes network scheduler: FSM encoding and the
// configuration-index to switch-select mapping.
package benes_pkg;

  localparam int unsigned CFG_W = 3;
  localparam int unsigned SEL_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETCFG,
    WAIT,
    STORE,
    DONE
  } state_t;

  // Configuration c selects switch pattern c*4 (c lands in select bits [4:2]).
  function automatic logic [SEL_W-1:0] cfg_sel(input logic [CFG_W-1:0] c);
    return SEL_W'({c, 2'b00});
  endfunction

endpackage

// File: rtl/benes_sched_wait_counter.sv
// Loadable down-counter that times the Benes network latency.
module wait_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] init,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= init;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/benes_sched.sv
// Benes network run scheduler: loads four words, sweeps NCFG switch
// configurations through the network and stores every result block.
module benes_sched
  import benes_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 16,
  parameter int unsigned SW   = 9,
  parameter int unsigned NCFG = 8,
  parameter int unsigned LAT  = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [AW-1:0]   in_base,
  input  logic [AW-1:0]   out_base,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [DW-1:0]   rd_data,
  output logic [4*DW-1:0] x_out,
  output logic [SW-1:0]   s_out,
  input  logic [4*DW-1:0] y_in,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CFG_W-1:0] C_LAST = CFG_W'(NCFG - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  state_t             state, state_n;
  logic [1:0]         k, k_n, k_inc;
  logic [CFG_W-1:0]   c, c_n;
  logic [AW-1:0]      in_base_q, out_base_q;
  logic               base_load;
  logic               rd_en_n, wr_en_n, done_n;
  logic [AW-1:0]      rd_addr_n, wr_addr_n;
  logic [DW-1:0]      wr_data_n;
  logic [SW-1:0]      s_out_n;
  logic               wc_load, y_load;
  logic [CW-1:0]      cnt;
  logic               rd_pend;
  logic [1:0]         rd_lane;
  logic [4*DW-1:0]    y_q;

  assign k_inc = k + 2'd1;

  wait_counter #(.W(CW)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (wc_load),
    .en   (state == WAIT),
    .init (CNT_INIT),
    .cnt  (cnt)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_n   = state;
    k_n       = k;
    c_n       = c;
    base_load = 1'b0;
    rd_en_n   = 1'b0;
    rd_addr_n = rd_addr;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    s_out_n   = s_out;
    done_n    = 1'b0;
    wc_load   = 1'b0;
    y_load    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = LOAD;
          base_load = 1'b1;
          k_n       = 2'd0;
          c_n       = '0;
          rd_en_n   = 1'b1;
          rd_addr_n = in_base;
        end
      end
      LOAD: begin
        if (k == 2'd3) begin
          state_n = SETCFG;
          s_out_n = SW'(cfg_sel(c));
        end else begin
          k_n       = k_inc;
          rd_en_n   = 1'b1;
          rd_addr_n = in_base_q + AW'(k_inc);
        end
      end
      SETCFG: begin
        state_n = WAIT;
        wc_load = 1'b1;
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n   = STORE;
          y_load    = 1'b1;
          k_n       = 2'd0;
          wr_en_n   = 1'b1;
          wr_addr_n = out_base_q + AW'({c, 2'b00});
          wr_data_n = y_in[0 +: DW];
        end
      end
      STORE: begin
        if (k == 2'd3) begin
          if (c == C_LAST) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = SETCFG;
            c_n     = c + CFG_W'(1);
            s_out_n = SW'(cfg_sel(c + CFG_W'(1)));
          end
        end else begin
          k_n       = k_inc;
          wr_en_n   = 1'b1;
          wr_addr_n = out_base_q + AW'({c, k_inc});
          wr_data_n = y_q[DW*int'(k_inc) +: DW];
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Abort overrides whatever transition was chosen above.
    if (abort && (state != IDLE)) begin
      state_n = IDLE;
      rd_en_n = 1'b0;
      wr_en_n = 1'b0;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= 2'd0;
      c          <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      s_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state   <= state_n;
      k       <= k_n;
      c       <= c_n;
      rd_en   <= rd_en_n;
      rd_addr <= rd_addr_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      s_out   <= s_out_n;
      busy    <= (state_n != IDLE);
      done    <= done_n;
      if (base_load) begin
        in_base_q  <= in_base;
        out_base_q <= out_base;
      end
    end
  end

  // Read data lands one cycle after its strobe; the lane tag travels with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_lane <= 2'd0;
      x_out   <= '0;
      y_q     <= '0;
    end else begin
      rd_pend <= rd_en;
      rd_lane <= k;
      if (rd_pend) begin
        x_out[DW*int'(rd_lane) +: DW] <= rd_data;
      end
      if (y_load) begin
        y_q <= y_in;
      end
    end
  end

endmodule

// File: tb/tb_benes_sched.sv
// Directed self-checking bench for benes_sched with a one-cycle-latency
// memory model and an identity network (y_in follows x_out).
module tb_benes_sched;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned SW = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [AW-1:0]   in_base = '0;
  logic [AW-1:0]   out_base = '0;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data = '0;
  logic [4*DW-1:0] x_out;
  logic [SW-1:0]   s_out;
  logic [4*DW-1:0] y_in;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            busy;
  logic            done;

  int tests = 0;
  int fails = 0;

  benes_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_base(in_base), .out_base(out_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .x_out(x_out), .s_out(s_out), .y_in(y_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign y_in = x_out;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {16'hD00D, a};
  endfunction

  // Memory model and event logs (cyc = index of the cycle just ended).
  int cyc = 0;
  int nwr = 0;
  int nrd = 0;
  int dn_cnt = 0;
  int dn_cyc = 0;
  logic [AW-1:0] wa [256];
  logic [DW-1:0] wd [256];
  int            wc [256];
  logic [AW-1:0] ra [64];
  logic [SW-1:0] slog [2048];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data <= rd_en ? memf(rd_addr) : '0;
    if (cyc < 2048) slog[cyc] <= s_out;
    if (wr_en && nwr < 256) begin
      wa[nwr] <= wr_addr;
      wd[nwr] <= wr_data;
      wc[nwr] <= cyc;
      nwr <= nwr + 1;
    end
    if (rd_en && nrd < 64) begin
      ra[nrd] <= rd_addr;
      nrd <= nrd + 1;
    end
    if (done) begin
      dn_cnt <= dn_cnt + 1;
      dn_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [AW-1:0] ib, input logic [AW-1:0] ob, output int t0);
    in_base  = ib;
    out_base = ob;
    start    = 1'b1;
    t0       = cyc;
    step(1);
    start    = 1'b0;
  endtask

  task automatic goto(input int t0, input int n);
    while (cyc < t0 + n) step(1);
  endtask

  task automatic wait_done(input int d0);
    int i = 0;
    while (dn_cnt == d0 && i < 300) begin
      step(1);
      i++;
    end
    chki("done_timeout", int'(dn_cnt != d0), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},    128'(busy),    128'(0));
    chk({tag, "_done"},    128'(done),    128'(0));
    chk({tag, "_rd_en"},   128'(rd_en),   128'(0));
    chk({tag, "_wr_en"},   128'(wr_en),   128'(0));
    chk({tag, "_rd_addr"}, 128'(rd_addr), 128'(0));
    chk({tag, "_wr_addr"}, 128'(wr_addr), 128'(0));
    chk({tag, "_wr_data"}, 128'(wr_data), 128'(0));
    chk({tag, "_s_out"},   128'(s_out),   128'(0));
    chk({tag, "_x_out"},   x_out,         128'(0));
  endtask

  task automatic check_run(input int t0, input int w0, input int r0,
                           input logic [AW-1:0] ib, input logic [AW-1:0] ob);
    logic [AW-1:0] ea;
    chki("done_cycle", dn_cyc, t0 + 101);
    chki("write_count", nwr - w0, 32);
    chki("read_count", nrd - r0, 4);
    for (int k = 0; k < 4; k++) begin
      ea = ib + AW'(k);
      chk("read_addr", 128'(ra[r0 + k]), 128'(ea));
    end
    for (int i = 0; i < 32; i++) begin
      ea = ob + AW'(i);
      chk("wr_addr", 128'(wa[w0 + i]), 128'(ea));
      ea = ib + AW'(i % 4);
      chk("wr_data", 128'(wd[w0 + i]), 128'(memf(ea)));
      chki("wr_cycle", wc[w0 + i], t0 + 13 + 12 * (i / 4) + (i % 4));
    end
  endtask

  initial begin
    int t0, w0, r0, d0;
    logic [127:0] xe;

    // Reset state
    step(2);
    chk_zero("reset");
    rst = 1'b0;
    step(2);
    chk_zero("idle");

    // Default run with a stray start at cycle 50
    w0 = nwr; r0 = nrd; d0 = dn_cnt;
    start_run(16'h0001, 16'h0100, t0);
    goto(t0, 50);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(d0);
    step(20);
    chki("single_done", dn_cnt - d0, 1);
    check_run(t0, w0, r0, 16'h0001, 16'h0100);
    for (int c = 0; c < 8; c++) begin
      chk("s_out_first", 128'(slog[t0 + 5 + 12 * c]), 128'(c * 4));
      chk("s_out_last",  128'(slog[t0 + 16 + 12 * c]), 128'(c * 4));
    end
    xe = {memf(16'd4), memf(16'd3), memf(16'd2), memf(16'd1)};
    chk("x_out_hold", x_out, xe);
    chk("busy_idle", 128'(busy), 128'(0));

    // Abort in cycle 40 (last write of config 2)
    w0 = nwr; d0 = dn_cnt;
    start_run(16'h0020, 16'h0200, t0);
    goto(t0, 40);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_rd_en", 128'(rd_en), 128'(0));
    chk("abort_wr_en", 128'(wr_en), 128'(0));
    step(40);
    chki("abort_writes", nwr - w0, 12);
    chki("abort_last_wr", wc[nwr - 1], t0 + 40);
    chki("abort_no_done", dn_cnt - d0, 0);

    // Reset during WAIT of config 3, then a wrapping run
    start_run(16'h0030, 16'h0300, t0);
    goto(t0, 45);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    step(2);
    rst = 1'b0;
    step(1);
    w0 = nwr; r0 = nrd; d0 = dn_cnt;
    start_run(16'hFFFE, 16'hFFF0, t0);
    wait_done(d0);
    step(3);
    check_run(t0, w0, r0, 16'hFFFE, 16'hFFF0);
    chk("wrap_c4_first", 128'(wa[w0 + 16]), 128'(16'h0000));
    chk("wrap_c4_last",  128'(wa[w0 + 19]), 128'(16'h0003));
    chk("wrap_read2", 128'(ra[r0 + 2]), 128'(16'h0000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
